// File: rtl/mem_stage_if.sv
// Shared types for the memory stage and the data-bus interface it masters.
// The package lives here so it compiles ahead of both the interface and the stage.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    mem_op_t     mem_op;
    logic [31:0] mem_data;
  } mem_params_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
  } wb_params_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } mem_state_t;

endpackage

// Data bus. req is raised by the master and held, together with we/addr/be/wdata,
// until the slave answers with ack or err in some cycle; that cycle ends the access.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata, err
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata, err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on the data bus, holds the MEM/WB register
// and stalls the upstream pipeline while a bus access is outstanding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  mem_params_t        mem_params,
  output logic               stall,
  mem_stage_if.master        dbus,
  output logic               wb_valid,
  output wb_params_t         wb_params,
  output logic               exc_misaligned,
  output logic               exc_bus,
  output logic [31:0]        exc_addr,
  output mem_state_t         state_dbg
);

  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

  mem_state_t  state;
  logic [7:0]  cnt_q;
  logic [31:0] ea_q;
  mem_op_t     op_q;
  logic [4:0]  rd_q;

  logic [31:0] ea;
  mem_op_t     op;
  logic        is_mem;
  logic        is_store;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  logic        timed_out;
  logic        term;
  logic        bus_fail;
  logic        is_load_q;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  assign state_dbg = state;
  assign ea        = mem_params.rd_data;
  assign op        = mem_params.mem_op;

  // Decode of the instruction currently sitting in EX/MEM.
  always_comb begin
    is_mem     = 1'b1;
    is_store   = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = 32'h0;
    unique case (op)
      MEM_OP_NONE: is_mem = 1'b0;
      MEM_OP_LB, MEM_OP_LBU: ;
      MEM_OP_LH, MEM_OP_LHU: misaligned = ea[0];
      MEM_OP_LW: misaligned = (ea[1:0] != 2'b00);
      MEM_OP_SB: begin
        is_store   = 1'b1;
        be_next    = 4'b0001 << ea[1:0];
        wdata_next = {4{mem_params.mem_data[7:0]}};
      end
      MEM_OP_SH: begin
        is_store   = 1'b1;
        misaligned = ea[0];
        be_next    = ea[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{mem_params.mem_data[15:0]}};
      end
      MEM_OP_SW: begin
        is_store   = 1'b1;
        misaligned = (ea[1:0] != 2'b00);
        wdata_next = mem_params.mem_data;
      end
      default: is_mem = 1'b0;
    endcase
  end

  // Terminating cycle: slave answered, or the request has waited out its budget.
  // err beats ack; a timeout only counts when the slave did not ack in that cycle.
  assign timed_out = (cnt_q == TIMEOUT);
  assign term      = (state == ST_BUS) && (dbus.ack || dbus.err || timed_out);
  assign bus_fail  = dbus.err || (!dbus.ack && timed_out);

  always_comb begin
    if (state == ST_IDLE) begin
      stall = in_valid && is_mem && !misaligned;
    end else begin
      stall = !term;
    end
  end

  // Little-endian lane extraction of load data, using the latched address and op.
  always_comb begin
    unique case (ea_q[1:0])
      2'd0: lane_byte = dbus.rdata[7:0];
      2'd1: lane_byte = dbus.rdata[15:8];
      2'd2: lane_byte = dbus.rdata[23:16];
      default: lane_byte = dbus.rdata[31:24];
    endcase
    lane_half = ea_q[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
    is_load_q = 1'b1;
    load_data = dbus.rdata;
    unique case (op_q)
      MEM_OP_LB:  load_data = {{24{lane_byte[7]}}, lane_byte};
      MEM_OP_LBU: load_data = {24'h0, lane_byte};
      MEM_OP_LH:  load_data = {{16{lane_half[15]}}, lane_half};
      MEM_OP_LHU: load_data = {16'h0, lane_half};
      MEM_OP_LW:  load_data = dbus.rdata;
      default: begin
        is_load_q = 1'b0;
        load_data = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt_q          <= 8'h0;
      ea_q           <= 32'h0;
      op_q           <= MEM_OP_NONE;
      rd_q           <= 5'h0;
      dbus.req       <= 1'b0;
      dbus.we        <= 1'b0;
      dbus.addr      <= 32'h0;
      dbus.be        <= 4'h0;
      dbus.wdata     <= 32'h0;
      wb_valid       <= 1'b0;
      wb_params      <= '0;
      exc_misaligned <= 1'b0;
      exc_bus        <= 1'b0;
      exc_addr       <= 32'h0;
    end else begin
      exc_misaligned <= 1'b0;
      exc_bus        <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!in_valid) begin
            wb_valid  <= 1'b0;
            wb_params <= '0;
          end else if (!is_mem) begin
            wb_valid          <= 1'b1;
            wb_params.rd_addr <= mem_params.rd_addr;
            wb_params.rd_data <= mem_params.rd_data;
          end else if (misaligned) begin
            wb_valid       <= 1'b1;
            wb_params      <= '0;
            exc_misaligned <= 1'b1;
            exc_addr       <= ea;
          end else begin
            wb_valid   <= 1'b0;
            state      <= ST_BUS;
            cnt_q      <= 8'h0;
            ea_q       <= ea;
            op_q       <= op;
            rd_q       <= mem_params.rd_addr;
            dbus.req   <= 1'b1;
            dbus.we    <= is_store;
            dbus.addr  <= {ea[31:2], 2'b00};
            dbus.be    <= be_next;
            dbus.wdata <= wdata_next;
          end
        end
        ST_BUS: begin
          if (term) begin
            state    <= ST_IDLE;
            dbus.req <= 1'b0;
            wb_valid <= 1'b1;
            if (bus_fail) begin
              wb_params <= '0;
              exc_bus   <= 1'b1;
              exc_addr  <= ea_q;
            end else if (is_load_q) begin
              wb_params.rd_addr <= rd_q;
              wb_params.rd_data <= load_data;
            end else begin
              wb_params <= '0;
            end
          end else begin
            cnt_q    <= cnt_q + 8'd1;
            wb_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a driver plays both EX/MEM and the bus slave, expected
// write-back results go into a queue, and a monitor checks each retiring instruction.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        bus;
    logic [31:0] eaddr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  mem_params_t mem_params;
  logic        stall;
  logic        wb_valid;
  wb_params_t  wb_params;
  logic        exc_misaligned;
  logic        exc_bus;
  logic [31:0] exc_addr;
  mem_state_t  state_dbg;

  mem_stage_if bus_if();

  exp_t exp_q[$];
  int   checks;
  int   failures;

  mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .mem_params     (mem_params),
    .stall          (stall),
    .dbus           (bus_if.master),
    .wb_valid       (wb_valid),
    .wb_params      (wb_params),
    .exc_misaligned (exc_misaligned),
    .exc_bus        (exc_bus),
    .exc_addr       (exc_addr),
    .state_dbg      (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=0x%08h req=0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input logic [4:0] rd, input logic [31:0] data,
                                  input logic chk_data, input logic mis, input logic bus,
                                  input logic [31:0] eaddr);
    exp_t e;
    e.rd = rd; e.data = data; e.chk_data = chk_data;
    e.mis = mis; e.bus = bus; e.eaddr = eaddr;
    return e;
  endfunction

  // Driver: presents one instruction, plays the slave, and checks bus and stall behaviour.
  task automatic do_op(input string name, input mem_op_t op, input logic [31:0] ea,
                       input logic [4:0] rd, input logic [31:0] mdata, input logic [31:0] rdata,
                       input int ack_lat, input bit give_ack, input bit give_err,
                       input int exp_stall, input int exp_req, input logic exp_we,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata, input exp_t e);
    int   n_stall;
    int   n_req;
    bit   done;
    logic [68:0] first;
    n_stall = 0;
    n_req   = 0;
    done    = 1'b0;
    first   = '0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid            = 1'b1;
    mem_params.rd_addr  = rd;
    mem_params.rd_data  = ea;
    mem_params.mem_op   = op;
    mem_params.mem_data = mdata;
    bus_if.rdata        = rdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (bus_if.req) begin
        n_req++;
        if (n_req == 1) begin
          first = {bus_if.addr, bus_if.we, bus_if.be, bus_if.wdata};
          check({name, "_addr"}, bus_if.addr, {ea[31:2], 2'b00});
          check({name, "_we"}, 32'(bus_if.we), 32'(exp_we));
          check({name, "_be"}, 32'(bus_if.be), 32'(exp_be));
          if (exp_we) check({name, "_wdata"}, bus_if.wdata, exp_wdata);
        end else begin
          check({name, "_stable"}, 32'({bus_if.addr, bus_if.we, bus_if.be, bus_if.wdata} == first), 32'd1);
        end
        if (n_req == ack_lat) begin
          bus_if.ack = give_ack;
          bus_if.err = give_err;
        end
      end
      #1;
      if (stall) n_stall++;
      else done = 1'b1;
      @(posedge clk); #1;
      bus_if.ack = 1'b0;
      bus_if.err = 1'b0;
    end
    in_valid   = 1'b0;
    mem_params = '0;
    if (!done) check({name, "_stall_bound"}, 32'(stall), 32'd0);
    check({name, "_stall_cycles"}, 32'(n_stall), 32'(exp_stall));
    check({name, "_req_cycles"}, 32'(n_req), 32'(exp_req));
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wb_rd_addr", 32'(wb_params.rd_addr), 32'(e.rd));
          if (e.chk_data) check("wb_rd_data", wb_params.rd_data, e.data);
          check("exc_misaligned", 32'(exc_misaligned), 32'(e.mis));
          check("exc_bus", 32'(exc_bus), 32'(e.bus));
          if (e.mis || e.bus) check("exc_addr", exc_addr, e.eaddr);
        end
      end else if (exc_misaligned || exc_bus) begin
        check("exc_without_wb", 32'({exc_misaligned, exc_bus}), 32'd0);
      end
    end
  end

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    mem_params   = '0;
    bus_if.ack   = 1'b0;
    bus_if.err   = 1'b0;
    bus_if.rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(bus_if.req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_params", 32'(wb_params), 32'd0);
    check("rst_exc", 32'({exc_misaligned, exc_bus}), 32'd0);
    check("rst_exc_addr", exc_addr, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    do_op("alu", MEM_OP_NONE, 32'h0000_1234, 5'd5, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1'b0, 4'h0, 32'h0,
          mk_exp(5'd5, 32'h0000_1234, 1, 0, 0, 32'h0));
    do_op("lb", MEM_OP_LB, 32'h0000_0103, 5'd7, 32'h0, 32'h80FF_FFFF, 1, 1, 0, 1, 1, 1'b0, 4'hF, 32'h0,
          mk_exp(5'd7, 32'hFFFF_FF80, 1, 0, 0, 32'h0));
    do_op("sh", MEM_OP_SH, 32'h0000_0202, 5'd8, 32'hAAAA_BEEF, 32'h0, 3, 1, 0, 3, 3, 1'b1, 4'hC, 32'hBEEF_BEEF,
          mk_exp(5'd0, 32'h0, 0, 0, 0, 32'h0));
    do_op("mis_lw", MEM_OP_LW, 32'h0000_0301, 5'd9, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1'b0, 4'h0, 32'h0,
          mk_exp(5'd0, 32'h0, 0, 1, 0, 32'h0000_0301));
    do_op("tmo", MEM_OP_LW, 32'h0000_0400, 5'd10, 32'h0, 32'h0, 0, 0, 0, TIMEOUT + 1, TIMEOUT + 1, 1'b0, 4'hF, 32'h0,
          mk_exp(5'd0, 32'h0, 0, 0, 1, 32'h0000_0400));
    do_op("ackerr", MEM_OP_LH, 32'h0000_0506, 5'd11, 32'h0, 32'h1234_5678, 1, 1, 1, 1, 1, 1'b0, 4'hF, 32'h0,
          mk_exp(5'd0, 32'h0, 0, 0, 1, 32'h0000_0506));
    do_op("lbu", MEM_OP_LBU, 32'h0000_0101, 5'd12, 32'h0, 32'h1122_8033, 1, 1, 0, 1, 1, 1'b0, 4'hF, 32'h0,
          mk_exp(5'd12, 32'h0000_0080, 1, 0, 0, 32'h0));
    do_op("lh", MEM_OP_LH, 32'h0000_0602, 5'd13, 32'h0, 32'h9ABC_0000, 1, 1, 0, 1, 1, 1'b0, 4'hF, 32'h0,
          mk_exp(5'd13, 32'hFFFF_9ABC, 1, 0, 0, 32'h0));
    do_op("lhu", MEM_OP_LHU, 32'h0000_0600, 5'd14, 32'h0, 32'h1234_8765, 1, 1, 0, 1, 1, 1'b0, 4'hF, 32'h0,
          mk_exp(5'd14, 32'h0000_8765, 1, 0, 0, 32'h0));
    do_op("lw", MEM_OP_LW, 32'h0000_0700, 5'd31, 32'h0, 32'hDEAD_BEEF, 2, 1, 0, 2, 2, 1'b0, 4'hF, 32'h0,
          mk_exp(5'd31, 32'hDEAD_BEEF, 1, 0, 0, 32'h0));
    do_op("sb", MEM_OP_SB, 32'h0000_0803, 5'd15, 32'h1234_56A5, 32'h0, 1, 1, 0, 1, 1, 1'b1, 4'h8, 32'hA5A5_A5A5,
          mk_exp(5'd0, 32'h0, 0, 0, 0, 32'h0));
    do_op("sw", MEM_OP_SW, 32'h0000_0900, 5'd16, 32'hCAFE_F00D, 32'h0, 2, 1, 0, 2, 2, 1'b1, 4'hF, 32'hCAFE_F00D,
          mk_exp(5'd0, 32'h0, 0, 0, 0, 32'h0));
    do_op("mis_sh", MEM_OP_SH, 32'h0000_0205, 5'd17, 32'h0000_1111, 32'h0, 0, 0, 0, 0, 0, 1'b0, 4'h0, 32'h0,
          mk_exp(5'd0, 32'h0, 0, 1, 0, 32'h0000_0205));
    do_op("err_sb", MEM_OP_SB, 32'h0000_0A01, 5'd18, 32'h0000_003C, 32'h0, 2, 0, 1, 2, 2, 1'b1, 4'h2, 32'h3C3C_3C3C,
          mk_exp(5'd0, 32'h0, 0, 0, 1, 32'h0000_0A01));

    // Reset while a request is pending: the abandoned load must not retire.
    @(posedge clk); #1;
    in_valid            = 1'b1;
    mem_params.rd_addr  = 5'd3;
    mem_params.rd_data  = 32'h0000_1000;
    mem_params.mem_op   = MEM_OP_LW;
    mem_params.mem_data = 32'h0;
    @(posedge clk); #1;
    check("rstbus_req_before", 32'(bus_if.req), 32'd1);
    in_valid   = 1'b0;
    mem_params = '0;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstbus_req", 32'(bus_if.req), 32'd0);
    check("rstbus_wb_valid", 32'(wb_valid), 32'd0);
    check("rstbus_stall", 32'(stall), 32'd0);
    check("rstbus_state", 32'(state_dbg), 32'(ST_IDLE));

    do_op("post_rst_lw", MEM_OP_LW, 32'h0000_1004, 5'd4, 32'h0, 32'h0BAD_F00D, 1, 1, 0, 1, 1, 1'b0, 4'hF, 32'h0,
          mk_exp(5'd4, 32'h0BAD_F00D, 1, 0, 0, 32'h0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage. Consumes mem_params_t from the EX/MEM register and performs loads/stores on the data bus through a req/ack handshake.
- Contains the MEM/WB pipeline register and drives wb_params_t to write-back.
- Raises stall to freeze IF..EX/MEM while a bus transaction is outstanding.
- The registered wb_params.rd_data is the source of the MEM/WB forwarding path.

Parameters:
- TIMEOUT_CYCLES, 255: cycles dbus_req may stay high without dbus_ack/dbus_err before the access is aborted as a bus error; range 1..255, 8-bit counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX/MEM holds a live instruction.
- mem_params  in  mem_params_t  rd_addr (5b), rd_data (32b; effective address for mem ops, ALU result otherwise), mem_op, mem_data (store data).
- stall  out  1  combinational; hold upstream pipeline this cycle.
- dbus_req  out  1  registered bus request.
- dbus_we  out  1  1 = store.
- dbus_addr  out  32  word-aligned address, {ea[31:2],2'b00}.
- dbus_be  out  4  byte enables, bit i = byte lane i (little-endian).
- dbus_wdata  out  32  store data, replicated across lanes.
- dbus_ack  in  1  access complete; dbus_rdata valid for loads.
- dbus_rdata  in  32  load data.
- dbus_err  in  1  slave error, terminates access like ack.
- wb_valid  out  1  registered; wb_params holds a retiring instruction.
- wb_params  out  wb_params_t  {rd_addr 5b, rd_data 32b}; rd_addr 0 = no register write.
- exc_misaligned  out  1  one-cycle pulse, aligned with wb_valid.
- exc_bus  out  1  one-cycle pulse on dbus_err or timeout, aligned with wb_valid.
- exc_addr  out  32  faulting effective address; holds until the next exception.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset during BUS drops dbus_req the next cycle; the slave must tolerate an abandoned request.
- New package types: wb_params_t; mem_op values MEM_OP_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- States: IDLE, BUS.
- IDLE, in_valid=0: wb_valid<=0, wb_params<='0.
- IDLE, in_valid with mem_op NONE: wb_params<={rd_addr, rd_data}, wb_valid<=1; stall=0; latency 1.
- IDLE, in_valid with mem op, misaligned (halfword ea[0]!=0, word ea[1:0]!=0):
  - no bus access; stall=0.
  - wb_valid<=1 with wb rd_addr forced 0.
  - exc_misaligned<=1, exc_addr<=ea.
- IDLE, in_valid with mem op, aligned: stall=1; next cycle dbus_req=1 with addr/we/be/wdata latched; state<=BUS; counter<=0.
- BUS:
  - dbus_req and all dbus_* outputs are held stable until a terminating cycle.
  - A terminating cycle is dbus_ack or dbus_err sampled high, or the counter reaching TIMEOUT_CYCLES.
  - Counter increments each non-terminating BUS cycle.
  - stall=1 except in the terminating cycle, where stall=0 so EX/MEM advances at that edge.
  - At the terminating edge: dbus_req<=0, state<=IDLE, wb_valid<=1.
  - ack and err in the same cycle: err wins.
- Load result from lane (ea[1:0]), little-endian.
  - LB/LBU: byte sign/zero-extended.
  - LH/LHU: half at ea[1] sign/zero-extended.
  - LW: full word.
  - wb rd_addr = mem_params.rd_addr.
- Stores:
  - SB: be=1<<ea[1:0], wdata={4{b}}.
  - SH: be=ea[1]?4'b1100:4'b0011, wdata={2{h}}.
  - SW: be=4'b1111.
  - wb rd_addr forced 0.
- Error/timeout: exc_bus<=1, exc_addr<=ea, wb rd_addr forced 0.
- Minimum aligned access: 2 cycles in stage (ack in first req cycle); back-to-back mem ops re-enter IDLE for one cycle, so there are no combinational bus-to-bus paths.
- exc_* pulses deassert the cycle after; wb_valid drops unless a new instruction retires.

Test Plan:
- ALU pass-through: in_valid, mem_op NONE, rd_addr=5, rd_data=0x1234 -> next cycle wb_valid=1, wb={5,0x1234}, stall never high.
- LB sign-extend: ea=0x103, dbus_rdata=0x80FF_FFFF, ack on first req cycle -> dbus_addr=0x100, be=4'b1111 ignored for load, wb rd_data=0xFFFF_FF80; stall high exactly 1 cycle.
- SH upper lane with 3-cycle ack delay: ea=0x202, mem_data=0xAAAA_BEEF -> dbus_we=1, be=4'b1100, wdata=0xBEEF_BEEF held stable 3 cycles, stall high 3 cycles, wb rd_addr=0.
- Misaligned LW: ea=0x301 -> no dbus_req, exc_misaligned pulse, exc_addr=0x301, wb_valid=1 with rd_addr=0.
- Timeout: TIMEOUT_CYCLES=4, no ack -> dbus_req drops after 4 counted cycles, exc_bus=1, exc_addr=ea. Separately, ack and err in the same cycle -> exc_bus=1.
- Reset mid-BUS: assert rst while req pending -> next cycle dbus_req=0, wb_valid=0, stall=0 with in_valid low; the following access proceeds normally.
